// File: rtl/pipeline_pkg.sv
// Shared definitions for the five-stage MIPS pipeline: opcodes, ALUOp classes,
// the ID/EX control bundle and default datapath widths.
package pipeline_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  // Registered control bundle of the EX slot; an all-zero value is a bubble.
  typedef struct packed {
    logic    valid;
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID stage (decoder, register file) and the ID/EX register.
interface id_ex_stage_if #(
  parameter int DATA_W = pipeline_pkg::DATA_W_DEF,
  parameter int REG_W  = pipeline_pkg::REG_W_DEF
);
  logic              RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in;
  logic              MemRead_in, MemWrite_in, Branch_in;
  logic [1:0]        ALUOp_in;
  logic [DATA_W-1:0] pc_plus4_in, read_data1_in, read_data2_in, sign_ext_in;
  logic [REG_W-1:0]  rs_in, rt_in, rd_in;
  logic              flush_in;

  logic              RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out;
  logic              MemRead_out, MemWrite_out, Branch_out;
  logic [1:0]        ALUOp_out;
  logic [DATA_W-1:0] pc_plus4_out, read_data1_out, read_data2_out, sign_ext_out;
  logic [REG_W-1:0]  rs_out, rt_out, rd_out;
  logic              valid_out;

  // No valid/ready pair: stall_out is a hold request, and upstream must keep PC
  // and IF/ID unchanged in any cycle it is high (PCWrite_out/IFIDWrite_out low).
  logic              stall_out, PCWrite_out, IFIDWrite_out;

  modport master (
    output RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in,
           Branch_in, ALUOp_in, pc_plus4_in, read_data1_in, read_data2_in,
           sign_ext_in, rs_in, rt_in, rd_in, flush_in,
    input  RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out,
           MemWrite_out, Branch_out, ALUOp_out, pc_plus4_out, read_data1_out,
           read_data2_out, sign_ext_out, rs_out, rt_out, rd_out, valid_out,
           stall_out, PCWrite_out, IFIDWrite_out
  );

  modport slave (
    input  RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in,
           Branch_in, ALUOp_in, pc_plus4_in, read_data1_in, read_data2_in,
           sign_ext_in, rs_in, rt_in, rd_in, flush_in,
    output RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out,
           MemWrite_out, Branch_out, ALUOp_out, pc_plus4_out, read_data1_out,
           read_data2_out, sign_ext_out, rs_out, rt_out, rd_out, valid_out,
           stall_out, PCWrite_out, IFIDWrite_out
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// Combinational load-use detector: a valid load in EX whose destination rt is
// read by the instruction in ID forces a one-cycle stall.
module hazard_detection_unit #(
  parameter int REG_W = pipeline_pkg::REG_W_DEF
) (
  input  logic             MemRead_out,
  input  logic             valid_out,
  input  logic [REG_W-1:0] rt_out,
  input  logic [REG_W-1:0] rs_in,
  input  logic [REG_W-1:0] rt_in,
  output logic             stall_out,
  output logic             PCWrite_out,
  output logic             IFIDWrite_out
);

  // rt_in is compared regardless of opcode; the occasional extra stall is accepted.
  assign stall_out = valid_out & MemRead_out & (rt_out != '0) &
                     ((rt_out == rs_in) | (rt_out == rt_in));

  assign PCWrite_out   = ~stall_out;
  assign IFIDWrite_out = ~stall_out;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble injection on flush or load-use stall.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  id_ex_stage_if.slave bus
);

  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] pc_plus4_q, read_data1_q, read_data2_q, sign_ext_q;
  logic [REG_W-1:0]  rs_q, rt_q, rd_q;
  logic              stall, pc_write, ifid_write;
  logic              bubble;

  hazard_detection_unit #(.REG_W(REG_W)) u_hazard (
    .MemRead_out   (ctrl_q.mem_read),
    .valid_out     (ctrl_q.valid),
    .rt_out        (rt_q),
    .rs_in         (bus.rs_in),
    .rt_in         (bus.rt_in),
    .stall_out     (stall),
    .PCWrite_out   (pc_write),
    .IFIDWrite_out (ifid_write)
  );

  assign bubble = bus.flush_in | stall;

  always_comb begin
    ctrl_d            = '0;
    ctrl_d.valid      = 1'b1;
    ctrl_d.reg_dst    = bus.RegDst_in;
    ctrl_d.alu_src    = bus.ALUSrc_in;
    ctrl_d.mem_to_reg = bus.MemToReg_in;
    ctrl_d.reg_write  = bus.RegWrite_in;
    ctrl_d.mem_read   = bus.MemRead_in;
    ctrl_d.mem_write  = bus.MemWrite_in;
    ctrl_d.branch     = bus.Branch_in;
    ctrl_d.alu_op     = alu_op_e'(bus.ALUOp_in);
    if (bubble) ctrl_d = '0;
  end

  // Data and specifiers load even on a bubble; with valid low nobody consumes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q       <= '0;
      pc_plus4_q   <= '0;
      read_data1_q <= '0;
      read_data2_q <= '0;
      sign_ext_q   <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      pc_plus4_q   <= bus.pc_plus4_in;
      read_data1_q <= bus.read_data1_in;
      read_data2_q <= bus.read_data2_in;
      sign_ext_q   <= bus.sign_ext_in;
      rs_q         <= bus.rs_in;
      rt_q         <= bus.rt_in;
      rd_q         <= bus.rd_in;
    end
  end

  assign bus.RegDst_out     = ctrl_q.reg_dst;
  assign bus.ALUSrc_out     = ctrl_q.alu_src;
  assign bus.MemToReg_out   = ctrl_q.mem_to_reg;
  assign bus.RegWrite_out   = ctrl_q.reg_write;
  assign bus.MemRead_out    = ctrl_q.mem_read;
  assign bus.MemWrite_out   = ctrl_q.mem_write;
  assign bus.Branch_out     = ctrl_q.branch;
  assign bus.ALUOp_out      = ctrl_q.alu_op;
  assign bus.valid_out      = ctrl_q.valid;
  assign bus.pc_plus4_out   = pc_plus4_q;
  assign bus.read_data1_out = read_data1_q;
  assign bus.read_data2_out = read_data2_q;
  assign bus.sign_ext_out   = sign_ext_q;
  assign bus.rs_out         = rs_q;
  assign bus.rt_out         = rt_q;
  assign bus.rd_out         = rd_q;
  assign bus.stall_out      = stall;
  assign bus.PCWrite_out    = pc_write;
  assign bus.IFIDWrite_out  = ifid_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: an EX-slot model checked every cycle plus
// hand-computed literal expectations for reset, pass-through, stall and flush.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DW), .REG_W(RW)) bus ();

  id_ex_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- model of the EX slot ----------------
  typedef struct {
    logic          regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0]    aluop;
    logic [DW-1:0] pc4, rd1, rd2, imm;
    logic [RW-1:0] rs, rt, rd;
    logic          valid;
  } slot_t;

  slot_t m;
  bit    m_ready    = 0;
  bit    m_data_cmp = 0;

  function automatic bit model_stall();
    return m.valid && m.memread && (m.rt != 0) &&
           ((m.rt == bus.rs_in) || (m.rt == bus.rt_in));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m = '{default: '0};
      m_data_cmp = 1;
      m_ready = 1;
    end else begin
      bit hz;
      hz = model_stall();
      m.pc4 = bus.pc_plus4_in; m.rd1 = bus.read_data1_in;
      m.rd2 = bus.read_data2_in; m.imm = bus.sign_ext_in;
      m.rs = bus.rs_in; m.rt = bus.rt_in; m.rd = bus.rd_in;
      if (bus.flush_in || hz) begin
        {m.regdst, m.alusrc, m.memtoreg, m.regwrite, m.memread, m.memwrite, m.branch} = '0;
        m.aluop = 2'b00;
        m.valid = 0;
        m_data_cmp = 0;
      end else begin
        m.regdst = bus.RegDst_in; m.alusrc = bus.ALUSrc_in; m.memtoreg = bus.MemToReg_in;
        m.regwrite = bus.RegWrite_in; m.memread = bus.MemRead_in;
        m.memwrite = bus.MemWrite_in; m.branch = bus.Branch_in; m.aluop = bus.ALUOp_in;
        m.valid = 1;
        m_data_cmp = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_ready) begin
      bit s;
      s = model_stall();
      chk("m_valid", bus.valid_out, m.valid);
      chk("m_ctrl", {bus.RegDst_out, bus.ALUSrc_out, bus.MemToReg_out, bus.RegWrite_out,
                     bus.MemRead_out, bus.MemWrite_out, bus.Branch_out, bus.ALUOp_out},
                    {m.regdst, m.alusrc, m.memtoreg, m.regwrite, m.memread, m.memwrite,
                     m.branch, m.aluop});
      chk("m_stall", bus.stall_out, s);
      chk("m_pcwrite", bus.PCWrite_out, !s);
      chk("m_ifidwrite", bus.IFIDWrite_out, !s);
      if (m_data_cmp) begin
        chk("m_pc4", bus.pc_plus4_out, m.pc4);
        chk("m_rd1", bus.read_data1_out, m.rd1);
        chk("m_rd2", bus.read_data2_out, m.rd2);
        chk("m_imm", bus.sign_ext_out, m.imm);
        chk("m_regs", {bus.rs_out, bus.rt_out, bus.rd_out}, {m.rs, m.rt, m.rd});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_ctrl(input logic [6:0] c, input logic [1:0] op);
    {bus.RegDst_in, bus.ALUSrc_in, bus.MemToReg_in, bus.RegWrite_in,
     bus.MemRead_in, bus.MemWrite_in, bus.Branch_in} = c;
    bus.ALUOp_in = op;
  endtask

  task automatic drive_data(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                            input logic [RW-1:0] rd, input logic [DW-1:0] d1);
    bus.rs_in = rs; bus.rt_in = rt; bus.rd_in = rd;
    bus.read_data1_in = d1;
    bus.read_data2_in = d1 ^ 32'hA5A5_0000;
    bus.sign_ext_in   = {27'd0, rd};
    bus.pc_plus4_in   = bus.pc_plus4_in + 32'd4;
  endtask

  // control order: RegDst ALUSrc MemToReg RegWrite MemRead MemWrite Branch
  task automatic set_rtype(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                           input logic [RW-1:0] rd, input logic [DW-1:0] d1);
    drive_ctrl(7'b1001000, ALU_FUNCT); drive_data(rs, rt, rd, d1);
  endtask

  task automatic set_lw(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
    drive_ctrl(7'b0111100, ALU_ADD); drive_data(rs, rt, 5'd0, 32'h0000_1000);
  endtask

  task automatic set_sw(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
    drive_ctrl(7'b0100010, ALU_ADD); drive_data(rs, rt, 5'd0, 32'h0000_2000);
  endtask

  task automatic set_nop();
    drive_ctrl(7'b0, ALU_ADD); drive_data(5'd0, 5'd0, 5'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    bus.flush_in = 1'b0;
    bus.pc_plus4_in = 32'h0040_0000;
    drive_ctrl(7'($urandom_range(127, 0)), 2'($urandom_range(3, 0)));
    drive_data(5'($urandom_range(31, 1)), 5'($urandom_range(31, 1)),
               5'($urandom_range(31, 0)), $urandom);
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", bus.valid_out, 1'b0);
    chk("rst_regwrite", bus.RegWrite_out, 1'b0);
    chk("rst_rd1", bus.read_data1_out, 32'd0);
    chk("rst_rt", bus.rt_out, 5'd0);
    chk("rst_stall", bus.stall_out, 1'b0);
    chk("rst_pcwrite", bus.PCWrite_out, 1'b1);

    // pass-through of an R-type
    set_rtype(5'd1, 5'd2, 5'd3, 32'h0000_0005);
    step();
    chk("pt_valid", bus.valid_out, 1'b1);
    chk("pt_regdst", bus.RegDst_out, 1'b1);
    chk("pt_regwrite", bus.RegWrite_out, 1'b1);
    chk("pt_aluop", bus.ALUOp_out, 2'b10);
    chk("pt_rd1", bus.read_data1_out, 32'h0000_0005);
    chk("pt_rd", bus.rd_out, 5'd3);

    // load-use on rs
    set_lw(5'd2, 5'd8);
    step();
    set_rtype(5'd8, 5'd4, 5'd9, 32'h1234_5678);
    #1;
    chk("lu_stall", bus.stall_out, 1'b1);
    chk("lu_pcwrite", bus.PCWrite_out, 1'b0);
    chk("lu_ifidwrite", bus.IFIDWrite_out, 1'b0);
    step();
    chk("lu_bub_valid", bus.valid_out, 1'b0);
    chk("lu_bub_memread", bus.MemRead_out, 1'b0);
    chk("lu_bub_regwrite", bus.RegWrite_out, 1'b0);
    chk("lu_bub_stall", bus.stall_out, 1'b0);
    step();
    chk("lu_cons_valid", bus.valid_out, 1'b1);
    chk("lu_cons_rs", bus.rs_out, 5'd8);
    chk("lu_cons_rd", bus.rd_out, 5'd9);

    // no false stall: load into $zero, then unrelated registers
    set_lw(5'd3, 5'd0);
    step();
    set_rtype(5'd0, 5'd0, 5'd5, 32'd7);
    #1;
    chk("nf_zero_stall", bus.stall_out, 1'b0);
    set_lw(5'd3, 5'd8);
    step();
    set_rtype(5'd9, 5'd10, 5'd11, 32'd9);
    #1;
    chk("nf_diff_stall", bus.stall_out, 1'b0);
    step();
    chk("nf_valid", bus.valid_out, 1'b1);

    // conservative rt match
    set_lw(5'd3, 5'd8);
    step();
    set_sw(5'd1, 5'd8);
    #1;
    chk("rt_stall", bus.stall_out, 1'b1);
    step();
    step();
    chk("rt_sw_memwrite", bus.MemWrite_out, 1'b1);

    // back-to-back dependent loads: one bubble per pair
    set_lw(5'd3, 5'd8);
    step();
    set_lw(5'd8, 5'd9);
    step();
    chk("bb_bubble1", bus.valid_out, 1'b0);
    step();
    set_rtype(5'd9, 5'd1, 5'd2, 32'd3);
    #1;
    chk("bb_stall2", bus.stall_out, 1'b1);
    step();
    chk("bb_bubble2", bus.valid_out, 1'b0);
    step();
    chk("bb_cons_valid", bus.valid_out, 1'b1);

    // flush with sw presented
    set_sw(5'd4, 5'd5);
    bus.flush_in = 1'b1;
    step();
    bus.flush_in = 1'b0;
    chk("fl_memwrite", bus.MemWrite_out, 1'b0);
    chk("fl_valid", bus.valid_out, 1'b0);

    // flush during a load-use stall
    set_lw(5'd3, 5'd8);
    step();
    set_rtype(5'd8, 5'd4, 5'd9, 32'd1);
    bus.flush_in = 1'b1;
    #1;
    chk("fs_stall", bus.stall_out, 1'b1);
    step();
    bus.flush_in = 1'b0;
    set_nop();
    #1;
    chk("fs_valid", bus.valid_out, 1'b0);
    chk("fs_stall_after", bus.stall_out, 1'b0);
    step();
    chk("fs_next_valid", bus.valid_out, 1'b1);

    // reset while stalling
    set_lw(5'd3, 5'd8);
    step();
    set_rtype(5'd8, 5'd8, 5'd9, 32'd2);
    #1;
    chk("rs_stall_pre", bus.stall_out, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rs_valid", bus.valid_out, 1'b0);
    chk("rs_memread", bus.MemRead_out, 1'b0);
    chk("rs_rt", bus.rt_out, 5'd0);
    chk("rs_stall", bus.stall_out, 1'b0);
    step();
    chk("rs_cons_valid", bus.valid_out, 1'b1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage MIPS pipeline, directly downstream of the main control decoder. Each cycle it registers the decoder's control bundle plus register-file operands, sign-extended immediate, PC+4 and register specifiers for the EX stage. It contains load-use hazard detection: it stalls PC and IF/ID and injects a bubble. It also squashes its contents on a taken-branch flush.

## Interface

- `DATA_W`, default 32: datapath width (operands, immediate, PC+4).
- `REG_W`, default 5: register-specifier width.
- `clk`, input, 1: clock; all state updates on rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `RegDst_in`, `ALUSrc_in`, `MemToReg_in`, `RegWrite_in`, `MemRead_in`, `MemWrite_in`, `Branch_in`, input, 1 each: control bundle from the decoder.
- `ALUOp_in`, input, 2: ALU operation class from the decoder.
- `pc_plus4_in`, `read_data1_in`, `read_data2_in`, `sign_ext_in`, input, DATA_W each: ID-stage values.
- `rs_in`, `rt_in`, `rd_in`, input, REG_W each: specifiers of the instruction currently in ID.
- `flush_in`, input, 1: taken branch resolved downstream; squash the instruction in ID.
- Registered copies of every control, data and specifier input above, output, same widths: named with the `_out` suffix.
- `valid_out`, output, 1: the EX-stage slot holds a real instruction.
- `stall_out`, output, 1: combinational load-use stall request. The PC and IF/ID register must hold while it is high.
- `PCWrite_out`, `IFIDWrite_out`, output, 1 each: `~stall_out`.

## Operation

- **Hazard condition:** `stall_out = valid_out & MemRead_out & (rt_out != 0) & (rt_out == rs_in | rt_out == rt_in)`.
  - Comparison is conservative: `rt_in` is always checked, whatever the opcode.
- **Update priority at each rising edge, highest first:**
  1. `reset`: all outputs registered to 0, `valid_out` = 0.
  2. `flush_in`: bubble.
     - All control outputs = 0, `ALUOp_out` = 2'b00, `valid_out` = 0.
     - Data and specifier outputs are loaded normally; their values are don't-care.
  3. `stall_out`: bubble, identical to the flush case.
     - The instruction in ID stays in ID because IF/ID holds.
  4. Otherwise: load all inputs, `valid_out` = 1.
- **Bubble semantics:** `RegWrite_out` = `MemWrite_out` = `MemRead_out` = `Branch_out` = 0. A bubble can therefore never modify architectural state or raise a new stall.
- **Single-stall rule:** a load-use stall lasts exactly one cycle.
  - After the bubble, `valid_out` = 0, so `stall_out` deasserts.
  - The held instruction then enters EX, and the forwarding unit resolves the dependency from MEM/WB.
- **Flush and stall together:** flush wins. The bubble is injected, and `stall_out` stays high combinationally for that cycle. This is harmless because the upstream flush also clears IF/ID.
- No arithmetic; all values are passed through at their declared widths.

## Timing

- Latency: inputs appear on the `_out` ports one cycle after the sampling edge.
- `stall_out`, `PCWrite_out` and `IFIDWrite_out` are combinational in the same cycle from registered state and the current `rs_in`/`rt_in`. There is no registered delay.
- **Reset:**
  - Every `_out` register is 0 and `valid_out` is 0.
  - Consequently `stall_out` = 0 and `PCWrite_out` = `IFIDWrite_out` = 1 from the first cycle after reset.
  - Reset asserted mid-stall: the next edge clears everything, and no stall persists.
- Back-to-back loads with dependent consumers produce one bubble per dependent pair, never two in a row for the same consumer.

## Structure

- Shared package `pipeline_pkg`:
  - opcode constants (R-type 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100);
  - ALUOp encodings (2'b00 add, 2'b01 sub, 2'b10 funct);
  - control-bundle width (10 bits);
  - `DATA_W`/`REG_W` defaults.
- One sub-module: `hazard_detection_unit`. It is purely combinational: inputs `MemRead_out`, `valid_out`, `rt_out`, `rs_in`, `rt_in`; outputs `stall_out`, `PCWrite_out`, `IFIDWrite_out`.
- The stage register, bubble mux and valid bit live in `id_ex_stage`.

## Test plan

- **Reset:** hold `reset` for 2 cycles with arbitrary inputs -> every `_out` = 0, `valid_out` = 0, `stall_out` = 0, `PCWrite_out` = 1.
- **Pass-through:** R-type control (RegDst=1, RegWrite=1, ALUOp=2'b10), `read_data1_in` = 32'h0000_0005, `rd_in` = 3 -> identical values on the `_out` ports after one edge, `valid_out` = 1.
- **Load-use:** lw with `rt_in` = 8 registered, then ID presents `rs_in` = 8 -> `stall_out` = 1 the same cycle. Next edge: bubble with all control = 0; `stall_out` drops. Following edge: the consumer loads with `valid_out` = 1.
- **No false stall:** lw with `rt_in` = 0 registered, then ID `rs_in` = 0 -> `stall_out` = 0. Also lw `rt_in` = 8 followed by consumer rs = 9, rt = 10 -> no stall.
- **Flush:** `flush_in` = 1 with sw control presented -> next cycle `MemWrite_out` = 0, `valid_out` = 0. Flush asserted during a load-use stall -> a single bubble, the flush honoured.
- **Reset during stall:** assert `reset` in the cycle `stall_out` = 1 -> next cycle all outputs 0 and `stall_out` = 0.
